// File: rtl/agent_pkg.sv
// Shared message layout and helpers for the agent scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package agent_pkg;

    localparam int MSG_W  = 160;
    localparam int ID_W   = 32;
    localparam int OP_W   = 64;
    localparam int ID_LSB = 0;
    localparam int AA_LSB = 32;
    localparam int BB_LSB = 96;

    // Request/result word: {bb, aa, id}; a zero id marks an empty slot.
    typedef struct packed {
        logic [OP_W-1:0] bb;
        logic [OP_W-1:0] aa;
        logic [ID_W-1:0] id;
    } msg_t;

    function automatic logic msg_valid(input logic [MSG_W-1:0] msg);
        return msg[ID_LSB +: ID_W] != '0;
    endfunction

endpackage

// File: rtl/agent_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, cyclic.
// Latency: purely combinational; the pointer register lives in the caller.
// Backpressure: none; any=0 when nobody requests.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Scan N positions starting at ptr, keep the first requester found.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                gnt[(int'(ptr) + i) % N] = 1'b1;
                gnt_idx                  = IW'((int'(ptr) + i) % N);
                any                      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/agent_sched.sv
// Fans one message stream out to NAGENTS agents and merges their results back.
// Latency: request to agent 1 cycle min; agent result to msgout 1 cycle.
// Backpressure: okin drops while the hold register is stuck; agents are popped only when the out slot frees.
module agent_sched
    import agent_pkg::*;
#(
    parameter int NAGENTS = 4,
    parameter int CNTW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NAGENTS-1:0]       agent_mask,
    input  logic [MSG_W-1:0]         msgin,
    output logic                     okin,
    output logic [MSG_W-1:0]         msgout,
    input  logic                     okout,
    output logic                     busy,
    output logic [CNTW-1:0]          outstanding,
    output logic                     overflow,
    output logic                     agent_en,
    output logic [NAGENTS*MSG_W-1:0] agent_msgin,
    input  logic [NAGENTS-1:0]       agent_okin,
    input  logic [NAGENTS*MSG_W-1:0] agent_msgout,
    output logic [NAGENTS-1:0]       agent_okout,
    input  logic [NAGENTS-1:0]       agent_busy
);

    localparam int             IW   = $clog2(NAGENTS);
    localparam logic [IW-1:0]  LAST = IW'(NAGENTS - 1);

    logic               r_hold_vld;
    msg_t               r_hold_msg;
    logic               r_out_vld;
    logic [MSG_W-1:0]   r_msgout;
    logic [IW-1:0]      r_dptr;
    logic [IW-1:0]      r_cptr;
    logic [CNTW-1:0]    r_outstanding;
    logic               r_overflow;

    logic [NAGENTS-1:0] w_eligible;
    logic [NAGENTS-1:0] w_req;
    logic [NAGENTS-1:0] w_dgnt;
    logic [NAGENTS-1:0] w_cgnt;
    logic [IW-1:0]      w_didx;
    logic [IW-1:0]      w_cidx;
    logic               w_dany;
    logic               w_cany;
    logic               w_fire_d;
    logic               w_fire_c;
    logic               w_accept;
    logic               w_slot_free;
    logic [MSG_W-1:0]   w_cmsg;

    for (genvar k = 0; k < NAGENTS; k++) begin : g_agent
        assign w_eligible[k] = agent_okin[k] && !agent_mask[k];
        assign w_req[k]      = msg_valid(agent_msgout[k*MSG_W +: MSG_W]);
        // Non-granted slices carry id 0, so each push is a single-cycle pulse.
        assign agent_msgin[k*MSG_W +: MSG_W] = (w_fire_d && w_dgnt[k]) ? r_hold_msg : '0;
    end

    rr_arbiter #(.N(NAGENTS), .IW(IW)) u_disp_arb (
        .req     (w_eligible),
        .ptr     (r_dptr),
        .gnt     (w_dgnt),
        .gnt_idx (w_didx),
        .any     (w_dany)
    );

    rr_arbiter #(.N(NAGENTS), .IW(IW)) u_coll_arb (
        .req     (w_req),
        .ptr     (r_cptr),
        .gnt     (w_cgnt),
        .gnt_idx (w_cidx),
        .any     (w_cany)
    );

    assign w_fire_d    = r_hold_vld && w_dany;
    assign okin        = !r_hold_vld || w_fire_d;
    assign w_accept    = okin && msg_valid(msgin);
    assign w_slot_free = !r_out_vld || okout;
    assign w_fire_c    = w_slot_free && w_cany;
    assign w_cmsg      = agent_msgout[int'(w_cidx)*MSG_W +: MSG_W];
    assign agent_okout = w_fire_c ? w_cgnt : '0;

    assign msgout      = r_msgout;
    assign outstanding = r_outstanding;
    assign overflow    = r_overflow;
    assign agent_en    = en;
    assign busy        = r_hold_vld || r_out_vld || (r_outstanding != '0) || (|agent_busy);

    // Dispatch hold register: refill on accept, empty on dispatch, advance pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld <= 1'b0;
            r_hold_msg <= '0;
            r_dptr     <= '0;
        end else begin
            if (w_accept) begin
                r_hold_msg <= msgin;
                r_hold_vld <= 1'b1;
            end else if (w_fire_d) begin
                r_hold_vld <= 1'b0;
            end
            if (w_fire_d) begin
                r_dptr <= (w_didx == LAST) ? '0 : w_didx + 1'b1;
            end
        end
    end

    // Collect output register: load the granted result, or clear once downstream pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_msgout  <= '0;
            r_cptr    <= '0;
        end else if (w_fire_c) begin
            r_out_vld <= 1'b1;
            r_msgout  <= w_cmsg;
            r_cptr    <= (w_cidx == LAST) ? '0 : w_cidx + 1'b1;
        end else if (okout && r_out_vld) begin
            r_out_vld <= 1'b0;
            r_msgout  <= '0;
        end
    end

    // Outstanding counter: saturates at all-ones (flagging overflow) and floors at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_overflow    <= 1'b0;
        end else if (w_fire_d && !w_fire_c) begin
            if (&r_outstanding) begin
                r_overflow <= 1'b1;
            end else begin
                r_outstanding <= r_outstanding + 1'b1;
            end
        end else if (w_fire_c && !w_fire_d && (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_agent_sched.sv
// Directed plus random bench for agent_sched against a cycle-level reference model.
// Latency: checks combinational outputs each cycle and registered outputs after each edge.
// Backpressure: random okout/agent_okin/mask exercise both stall paths.
module tb_agent_sched;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int MW = 160;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    agent_mask;
    logic [MW-1:0]   msgin;
    logic            okin;
    logic [MW-1:0]   msgout;
    logic            okout;
    logic            busy;
    logic [CW-1:0]   outstanding;
    logic            overflow;
    logic            agent_en;
    logic [N*MW-1:0] agent_msgin;
    logic [N-1:0]    agent_okin;
    logic [N*MW-1:0] agent_msgout;
    logic [N-1:0]    agent_okout;
    logic [N-1:0]    agent_busy;

    agent_sched #(.NAGENTS(N), .CNTW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .agent_mask   (agent_mask),
        .msgin        (msgin),
        .okin         (okin),
        .msgout       (msgout),
        .okout        (okout),
        .busy         (busy),
        .outstanding  (outstanding),
        .overflow     (overflow),
        .agent_en     (agent_en),
        .agent_msgin  (agent_msgin),
        .agent_okin   (agent_okin),
        .agent_msgout (agent_msgout),
        .agent_okout  (agent_okout),
        .agent_busy   (agent_busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: what the scheduler should be holding.
    bit          m_hold_vld;
    logic [MW-1:0] m_hold_msg;
    bit          m_out_vld;
    logic [MW-1:0] m_msgout;
    int          m_dptr;
    int          m_cptr;
    int          m_cnt;
    bit          m_ovf;
    int          dg;
    int          cg;
    bit          fd;
    bit          fc;

    task automatic chk(input string tag, input logic [N*MW-1:0] obs, input logic [N*MW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic [31:0] id);
        if (id == 0) return '0;
        return {$urandom, $urandom, $urandom, $urandom, id};
    endfunction

    task automatic mdl_reset();
        m_hold_vld = 0; m_hold_msg = '0; m_out_vld = 0; m_msgout = '0;
        m_dptr = 0; m_cptr = 0; m_cnt = 0; m_ovf = 0;
    endtask

    // Winner search directly from the rules: first qualifying agent scanning from the pointer.
    task automatic mdl_eval();
        dg = -1;
        cg = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_dptr + i) % N;
            if (dg < 0 && agent_okin[k] && !agent_mask[k]) dg = k;
        end
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_cptr + i) % N;
            if (cg < 0 && agent_msgout[k*MW +: 32] != 0) cg = k;
        end
        fd = m_hold_vld && (dg >= 0);
        fc = (!m_out_vld || okout) && (cg >= 0);
    endtask

    task automatic mdl_clock();
        bit acc;
        acc = (!m_hold_vld || fd) && (msgin[31:0] != 0);
        if (acc) begin
            m_hold_msg = msgin;
            m_hold_vld = 1;
        end else if (fd) begin
            m_hold_vld = 0;
        end
        if (fd) m_dptr = (dg + 1) % N;
        if (fc) begin
            m_msgout  = agent_msgout[cg*MW +: MW];
            m_out_vld = 1;
            m_cptr    = (cg + 1) % N;
        end else if (okout && m_out_vld) begin
            m_out_vld = 0;
            m_msgout  = '0;
        end
        if (fd && !fc) begin
            if (m_cnt == (1 << CW) - 1) m_ovf = 1;
            else m_cnt++;
        end else if (fc && !fd && m_cnt > 0) begin
            m_cnt--;
        end
    endtask

    task automatic chk_now();
        logic [N*MW-1:0] ev;
        logic [N-1:0]    eo;
        mdl_eval();
        ev = '0;
        eo = '0;
        if (fd) ev[dg*MW +: MW] = m_hold_msg;
        if (fc) eo[cg] = 1'b1;
        chk("okin", okin, !m_hold_vld || fd);
        chk("agent_msgin", agent_msgin, ev);
        chk("agent_okout", agent_okout, eo);
        chk("msgout", msgout, m_msgout);
        chk("outstanding", outstanding, m_cnt);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_hold_vld || m_out_vld || m_cnt != 0 || |agent_busy);
        chk("agent_en", agent_en, en);
    endtask

    task automatic cyc();
        #1;
        chk_now();
        mdl_clock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; en = 1; agent_mask = '0; msgin = '0; okout = 0;
        agent_okin = '0; agent_msgout = '0; agent_busy = '0;
        mdl_reset();
        #2;
        chk_now();
        chk("rst_okin", okin, 1);
        chk("rst_msgout", msgout, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Four back-to-back requests rotate across agents 0..3.
        agent_okin = 4'b1111;
        for (int i = 1; i <= 4; i++) begin
            msgin = mk(i);
            #1;
            chk("t1_okin", okin, 1);
            if (i > 1) chk("t1_disp_id", agent_msgin[(i-2)*MW +: 32], i - 1);
            cyc();
        end
        msgin = '0;
        #1;
        chk("t1_disp_id4", agent_msgin[3*MW +: 32], 4);
        cyc();
        chk("t1_outstanding", outstanding, 4);

        // Only agent 2 eligible; then all full, then agent 3 frees up.
        agent_okin = 4'b0101;
        agent_mask = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            msgin = mk(32'h10 + i);
            #1;
            if (i > 0) chk("t2_to_agent2", agent_msgin[2*MW +: 32], 32'h10 + i - 1);
            cyc();
        end
        msgin = '0;
        #1;
        chk("t2_to_agent2_last", agent_msgin[2*MW +: 32], 32'h12);
        cyc();
        agent_okin = 4'b0000;
        msgin = mk(32'h20);
        #1;
        chk("t2_accept4", okin, 1);
        cyc();
        msgin = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stalled_okin", okin, 0);
            cyc();
        end
        agent_okin = 4'b1000;
        #1;
        chk("t2_release_okin", okin, 1);
        chk("t2_to_agent3", agent_msgin[3*MW +: 32], 32'h20);
        cyc();
        chk("t2_outstanding", outstanding, 8);

        // Simultaneous results from agents 1 and 3 drain in RR order.
        agent_mask = '0;
        agent_msgout[1*MW +: MW] = mk(7);
        agent_msgout[3*MW +: MW] = mk(9);
        okout = 1;
        #1;
        chk("t3_pop1", agent_okout, 4'b0010);
        cyc();
        agent_msgout[1*MW +: MW] = '0;
        #1;
        chk("t3_pop3", agent_okout, 4'b1000);
        chk("t3_id7", msgout[31:0], 7);
        cyc();
        agent_msgout[3*MW +: MW] = '0;
        agent_msgout[0*MW +: MW] = mk(32'h11);
        okout = 0;
        #1;
        chk("t3_id9", msgout[31:0], 9);
        chk("t4_no_pop", agent_okout, 0);
        cyc();
        chk("t4_stable", msgout[31:0], 9);
        cyc();
        okout = 1;
        #1;
        chk("t4_pop0", agent_okout, 4'b0001);
        cyc();
        agent_msgout[0*MW +: MW] = '0;
        okout = 0;
        #1;
        chk("t4_replaced", msgout[31:0], 32'h11);
        chk("t4_outstanding", outstanding, 5);
        cyc();

        // Dispatch and collect on the same edge leave the count unchanged.
        agent_okin = 4'b1111;
        msgin = mk(32'h21);
        cyc();
        msgin = '0;
        agent_msgout[1*MW +: MW] = mk(32'h31);
        okout = 1;
        #1;
        chk("t5_disp0", agent_msgin[0*MW +: 32], 32'h21);
        chk("t5_pop1", agent_okout, 4'b0010);
        cyc();
        chk("t5_outstanding", outstanding, 5);
        agent_msgout[1*MW +: MW] = '0;
        cyc();
        okout = 0;

        // Saturate the 4-bit counter and check the sticky overflow.
        for (int i = 0; i <= 10; i++) begin
            msgin = mk(32'h40 + i);
            cyc();
            if (i == 10) begin
                chk("t5_cnt15", outstanding, 15);
                chk("t5_no_ovf_yet", overflow, 0);
            end
        end
        msgin = '0;
        cyc();
        chk("t5_sat", outstanding, 15);
        chk("t5_ovf", overflow, 1);
        cyc();
        chk("t5_ovf_sticky", overflow, 1);

        // Asynchronous reset with both hold and out registers occupied.
        agent_okin = '0;
        msgin = mk(32'h77);
        cyc();
        msgin = '0;
        agent_msgout[2*MW +: MW] = mk(32'h88);
        cyc();
        chk("t6_pre_out", msgout[31:0], 32'h88);
        chk("t6_pre_hold", okin, 0);
        agent_msgout = '0;
        #1;
        rst_n = 0;
        mdl_reset();
        #1;
        chk_now();
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_okin", okin, 1);
        @(posedge clk);
        #1;
        chk_now();
        rst_n = 1;
        agent_okin = 4'b1111;
        msgin = mk(32'h55);
        cyc();
        msgin = '0;
        #1;
        chk("t6_post_disp0", agent_msgin[0*MW +: 32], 32'h55);
        cyc();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            en         = 1'($urandom);
            msgin      = ($urandom_range(0, 1) == 1) ? mk($urandom_range(1, 255)) : '0;
            agent_okin = 4'($urandom);
            agent_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            for (int k = 0; k < N; k++)
                agent_msgout[k*MW +: MW] = ($urandom_range(0, 2) == 0) ? mk($urandom_range(1, 255)) : '0;
            okout      = ($urandom_range(0, 3) != 0);
            agent_busy = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
